// File: rtl/character_sprite_render.sv
// character_sprite_render
//   Per-pixel character sprite colour lookup for the VGA mixer.
//   The character id/position/facing is shadowed once per frame on frame_start,
//   then each pixel request passes through a 3-stage pipeline wrapped around an
//   external synchronous sprite ROM (address out, data back one cycle later).
//   Optional feature macro: SPRITE_FLIP_EN enables horizontal mirroring
//   driven by char_face_left; without it char_face_left is ignored.
module character_sprite_render #(
    parameter int unsigned             COORD_WIDTH       = 10,
    parameter int unsigned             SPRITE_LOG2       = 5,
    parameter int unsigned             NUM_SPRITES       = 7,
    parameter int unsigned             PIXEL_WIDTH       = 12,
    parameter logic [PIXEL_WIDTH-1:0]  TRANSPARENT_COLOR = 12'hF0F
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic                        frame_start,
    input  logic [2:0]                  char_display_id,
    input  logic [COORD_WIDTH-1:0]      char_x,
    input  logic [COORD_WIDTH-1:0]      char_y,
    input  logic                        char_face_left,
    input  logic                        pix_valid,
    input  logic [COORD_WIDTH-1:0]      pix_x,
    input  logic [COORD_WIDTH-1:0]      pix_y,
    output logic [3+2*SPRITE_LOG2-1:0]  rom_addr,
    input  logic [PIXEL_WIDTH-1:0]      rom_data,
    output logic                        out_valid,
    output logic                        out_hit,
    output logic [PIXEL_WIDTH-1:0]      out_color
);

    localparam logic [3:0] NUM_SPRITES_W = 4'(NUM_SPRITES);

    logic [2:0]             r_sh_id;
    logic [COORD_WIDTH-1:0] r_sh_x;
    logic [COORD_WIDTH-1:0] r_sh_y;

    logic [COORD_WIDTH:0]   w_dx;
    logic [COORD_WIDTH:0]   w_dy;
    logic                   w_dx_ok;
    logic                   w_dy_ok;
    logic                   w_id_ok;
    logic                   w_inbox;
    logic [SPRITE_LOG2-1:0] w_lx;
    logic [SPRITE_LOG2-1:0] w_ly;

    logic                   r_s1_valid;
    logic                   r_s1_inbox;
    logic                   r_s2_valid;
    logic                   r_s2_inbox;
    logic                   w_hit;

    // Frame shadow of the character state, updated only at vertical blanking
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sh_id <= '0;
            r_sh_x  <= '0;
            r_sh_y  <= '0;
        end else if (frame_start) begin
            r_sh_id <= char_display_id;
            r_sh_x  <= char_x;
            r_sh_y  <= char_y;
        end
    end

`ifdef SPRITE_FLIP_EN
    logic r_sh_face;

    // Facing is shadowed with the rest of the character state
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sh_face <= 1'b0;
        end else if (frame_start) begin
            r_sh_face <= char_face_left;
        end
    end

    // (side-1) - dx within SPRITE_LOG2 bits is the bitwise inverse of dx
    assign w_lx = r_sh_face ? ~w_dx[SPRITE_LOG2-1:0] : w_dx[SPRITE_LOG2-1:0];
`else
    logic w_unused_face;
    assign w_unused_face = char_face_left;
    assign w_lx          = w_dx[SPRITE_LOG2-1:0];
`endif

    // Sign bit plus every bit at or above SPRITE_LOG2 must be clear to lie in the box
    assign w_dx    = {1'b0, pix_x} - {1'b0, r_sh_x};
    assign w_dy    = {1'b0, pix_y} - {1'b0, r_sh_y};
    assign w_dx_ok = (w_dx[COORD_WIDTH:SPRITE_LOG2] == '0);
    assign w_dy_ok = (w_dy[COORD_WIDTH:SPRITE_LOG2] == '0);
    assign w_id_ok = ({1'b0, r_sh_id} < NUM_SPRITES_W);
    assign w_inbox = w_dx_ok && w_dy_ok && w_id_ok;
    assign w_ly    = w_dy[SPRITE_LOG2-1:0];

    // S1: box test and ROM address; the address holds between requests
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_inbox <= 1'b0;
            rom_addr   <= '0;
        end else begin
            r_s1_valid <= pix_valid;
            r_s1_inbox <= pix_valid && w_inbox;
            if (pix_valid) begin
                rom_addr <= w_inbox ? {r_sh_id, w_ly, w_lx} : '0;
            end
        end
    end

    // S2: carry valid/inbox alongside the ROM read
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_inbox <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_inbox <= r_s1_inbox;
        end
    end

    assign w_hit = r_s2_inbox && (rom_data != TRANSPARENT_COLOR);

    // S3: registered colour result
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            out_valid <= 1'b0;
            out_hit   <= 1'b0;
            out_color <= '0;
        end else begin
            out_valid <= r_s2_valid;
            out_hit   <= w_hit;
            out_color <= w_hit ? rom_data : '0;
        end
    end

endmodule

// File: tb/tb_character_sprite_render.sv
// Testbench for character_sprite_render: table-driven directed vectors,
// hand-written sequences for frame_start timing and mid-frame reset, and
// randomized traffic checked against a per-request reference model.
module tb_character_sprite_render;

`ifdef SPRITE_FLIP_EN
    localparam bit FLIP = 1'b1;
`else
    localparam bit FLIP = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [2:0]  char_display_id = '0;
    logic [9:0]  char_x = '0;
    logic [9:0]  char_y = '0;
    logic        char_face_left = 1'b0;
    logic        pix_valid = 1'b0;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic [12:0] rom_addr;
    logic [11:0] rom_data = '0;
    logic        out_valid;
    logic        out_hit;
    logic [11:0] out_color;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 sys_clk = ~sys_clk;

    character_sprite_render #(
        .COORD_WIDTH      (10),
        .SPRITE_LOG2      (5),
        .NUM_SPRITES      (7),
        .PIXEL_WIDTH      (12),
        .TRANSPARENT_COLOR(12'hF0F)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .frame_start    (frame_start),
        .char_display_id(char_display_id),
        .char_x         (char_x),
        .char_y         (char_y),
        .char_face_left (char_face_left),
        .pix_valid      (pix_valid),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .out_valid      (out_valid),
        .out_hit        (out_hit),
        .out_color      (out_color)
    );

    // Sprite ROM contents: a few fixed entries, every 8th word transparent
    function automatic logic [11:0] rom_fn(input logic [12:0] a);
        if (a == 13'd0)       return 12'h0AB;
        if (a == 13'd3072)    return 12'h123;
        if (a[2:0] == 3'd0)   return 12'hF0F;
        return a[11:0];
    endfunction

    // Synchronous ROM: data one cycle after the address
    always @(posedge sys_clk) rom_data <= rom_fn(rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct { bit v; bit h; logic [11:0] c; } ent_t;
    int          m_id, m_x, m_y;
    bit          m_face;
    logic [12:0] e_addr;
    ent_t        d1, d2, d3;

    task automatic model_reset();
        m_id = 0; m_x = 0; m_y = 0; m_face = 1'b0;
        e_addr = '0;
        d1 = '{default: 0}; d2 = '{default: 0}; d3 = '{default: 0};
    endtask

    // One clock: predict from the current inputs, advance, then check
    task automatic step();
        ent_t e;
        int   dx, dy, lx, addr;
        bit   inb;
        dx   = int'(pix_x) - m_x;
        dy   = int'(pix_y) - m_y;
        inb  = pix_valid && dx >= 0 && dx < 32 && dy >= 0 && dy < 32 && m_id < 7;
        lx   = (FLIP && m_face) ? 31 - dx : dx;
        addr = inb ? m_id * 1024 + dy * 32 + lx : 0;
        e.v  = pix_valid;
        e.c  = inb ? rom_fn(13'(addr)) : 12'h000;
        e.h  = inb && (e.c != 12'hF0F);
        if (!e.h) e.c = 12'h000;
        if (pix_valid) e_addr = 13'(addr);
        if (frame_start && sys_rst_n) begin
            m_id = int'(char_display_id); m_x = int'(char_x); m_y = int'(char_y);
            m_face = char_face_left;
        end
        d3 = d2; d2 = d1; d1 = e;
        @(posedge sys_clk);
        #1;
        if (!sys_rst_n) model_reset();
        chk("model rom_addr",  32'(rom_addr),  32'(e_addr));
        chk("model out_valid", 32'(out_valid), 32'(d3.v));
        chk("model out_hit",   32'(out_hit),   32'(d3.h));
        chk("model out_color", 32'(out_color), 32'(d3.c));
    endtask

    typedef struct {
        bit fs; logic [2:0] id; logic [9:0] x, y; bit face;
        logic [9:0] px, py; logic [12:0] ea; bit eh; logic [11:0] ec;
    } vec_t;

    function automatic vec_t mk(int fs, int id, int x, int y, int face, int px, int py,
                                int ea, int eh, int ec);
        vec_t v;
        v.fs = fs[0]; v.id = 3'(id); v.x = 10'(x); v.y = 10'(y); v.face = face[0];
        v.px = 10'(px); v.py = 10'(py); v.ea = 13'(ea); v.eh = eh[0]; v.ec = 12'(ec);
        return v;
    endfunction

    task automatic apply_vec(input int idx, input vec_t v);
        char_display_id = v.id; char_x = v.x; char_y = v.y; char_face_left = v.face;
        if (v.fs) begin
            frame_start = 1'b1; pix_valid = 1'b0;
            step();
            frame_start = 1'b0;
        end
        pix_valid = 1'b1; pix_x = v.px; pix_y = v.py;
        step();
        chk($sformatf("vec%0d rom_addr", idx), 32'(rom_addr), 32'(v.ea));
        pix_valid = 1'b0;
        step();
        step();
        chk($sformatf("vec%0d out_valid", idx), 32'(out_valid), 32'd1);
        chk($sformatf("vec%0d out_hit", idx),   32'(out_hit),   32'(v.eh));
        chk($sformatf("vec%0d out_color", idx), 32'(out_color), 32'(v.ec));
    endtask

    vec_t vt[15];

    initial begin
        vt[0]  = mk(0, 0,    0,   0, 0,    0,   0,    0, 1, 'h0AB);
        vt[1]  = mk(1, 3,  100, 200, 0,  100, 200, 3072, 1, 'h123);
        vt[2]  = mk(0, 3,  100, 200, 0,  131, 231, 4095, 1, 'hFFF);
        vt[3]  = mk(0, 3,  100, 200, 0,  132, 200,    0, 0, 0);
        vt[4]  = mk(0, 3,  100, 200, 0,   99, 200,    0, 0, 0);
        vt[5]  = mk(0, 3,  100, 200, 0,  100, 199,    0, 0, 0);
        vt[6]  = mk(1, 3,  100, 200, 1,  100, 205, FLIP ? 3263 : 3232,
                    FLIP ? 1 : 0, FLIP ? 'hCBF : 0);
        vt[7]  = mk(1, 3,  100, 200, 0,  108, 200, 3080, 0, 0);
        vt[8]  = mk(0, 3,  300, 200, 0,  100, 200, 3072, 1, 'h123);
        vt[9]  = mk(1, 3,  300, 200, 0,  100, 200,    0, 0, 0);
        vt[10] = mk(1, 7,  100, 200, 0,  100, 200,    0, 0, 0);
        vt[11] = mk(0, 7,  100, 200, 0,  131, 231,    0, 0, 0);
        vt[12] = mk(1, 2, 1010,   0, 0, 1023,   3, 2157, 1, 'h86D);
        vt[13] = mk(0, 2, 1010,   0, 0,    5,   3,    0, 0, 0);
        vt[14] = mk(1, 0,    0,   0, 0,   31,   0,   31, 1, 'h01F);

        model_reset();

        // Reset held with a live request: everything stays at zero
        pix_valid = 1'b1; pix_x = '0; pix_y = '0;
        step();
        step();
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst rom_addr",  32'(rom_addr),  32'd0);
        pix_valid = 1'b0;
        sys_rst_n = 1'b1;

        for (int i = 0; i < 15; i++) apply_vec(i, vt[i]);

        // frame_start in the same cycle as a pixel: the pixel sees the old shadow
        char_display_id = 3'd3; char_x = 10'd100; char_y = 10'd200; char_face_left = 1'b0;
        frame_start = 1'b1; pix_valid = 1'b1; pix_x = 10'd100; pix_y = 10'd200;
        step();
        chk("samecyc addr old", 32'(rom_addr), 32'd0);
        frame_start = 1'b0;
        step();
        chk("samecyc addr new", 32'(rom_addr), 32'd3072);
        pix_valid = 1'b0;
        step();
        chk("samecyc old valid", 32'(out_valid), 32'd1);
        chk("samecyc old hit",   32'(out_hit),   32'd0);
        step();
        chk("samecyc new hit",   32'(out_hit),   32'd1);
        chk("samecyc new color", 32'(out_color), 32'h123);
        step();
        chk("samecyc bubble",    32'(out_valid), 32'd0);

        // Reset in mid-stream flushes everything in flight
        pix_valid = 1'b1;
        step();
        step();
        step();
        sys_rst_n = 1'b0;
        #2;
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst out_hit",   32'(out_hit),   32'd0);
        chk("midrst out_color", 32'(out_color), 32'd0);
        chk("midrst rom_addr",  32'(rom_addr),  32'd0);
        pix_valid = 1'b0;
        step();
        sys_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("postrst out_valid", 32'(out_valid), 32'd0);
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 800; i++) begin
            frame_start = ($urandom_range(0, 15) == 0);
            if (frame_start) begin
                char_display_id = 3'($urandom_range(0, 7));
                char_x = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(990, 1023))
                                                      : 10'($urandom_range(0, 1023));
                char_y = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(990, 1023))
                                                      : 10'($urandom_range(0, 1023));
                char_face_left = 1'($urandom_range(0, 1));
            end
            pix_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                pix_x = 10'($urandom_range(0, 1023));
                pix_y = 10'($urandom_range(0, 1023));
            end else begin
                pix_x = 10'(m_x - 4 + int'($urandom_range(0, 40)));
                pix_y = 10'(m_y - 4 + int'($urandom_range(0, 40)));
            end
            step();
        end
        frame_start = 1'b0;
        pix_valid = 1'b0;
        step();
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
